// File: rtl/vcve2_mem_responder.sv
// Word-addressed memory responder for the core's req/gnt/rvalid bus.
// Fixed-latency in-order responses, byte-enable writes, outstanding-limit grant throttling.
module vcve2_mem_responder #(
  parameter int          Depth          = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int          Latency        = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        gnt_stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(Depth);
  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam logic [OW-1:0] MaxOut = OW'(MaxOutstanding);
  localparam logic [32:0] Base33 = {1'b0, BaseAddr};
  localparam logic [32:0] End33  = Base33 + 33'(Depth) * 33'd4;

  logic [31:0]        r_mem [Depth];
  logic [Latency-1:0] r_vld;
  logic [Latency-1:0] r_err;
  logic [31:0]        r_rdata [Latency];
  logic [OW-1:0]      r_outst;

  logic          w_accept;
  logic          w_err;
  logic          w_wr;
  logic          w_rd;
  logic [32:0]   w_addr33;
  logic [AW-1:0] w_idx;

  assign rvalid_o = r_vld[Latency-1];
  assign rdata_o  = r_rdata[Latency-1];
  assign err_o    = r_err[Latency-1];

  // A retiring response frees its slot in the same cycle, so full occupancy does not bubble.
  assign gnt_o    = !rst_i && !gnt_stall_i && ((r_outst < MaxOut) || rvalid_o);
  assign w_accept = req_i && gnt_o;

  // 33-bit compare keeps the top-of-address-space check from wrapping.
  assign w_addr33 = {1'b0, addr_i};
  assign w_err    = (addr_i[1:0] != 2'b00) || (w_addr33 < Base33) || (w_addr33 >= End33);
  assign w_idx    = AW'((addr_i - BaseAddr) >> 2);
  assign w_wr     = w_accept && we_i && !w_err;
  assign w_rd     = w_accept && !we_i && !w_err;

  // Memory has no reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < Latency; i++) begin
        r_rdata[i] <= '0;
      end
    end else begin
      r_vld[0]   <= w_accept;
      r_err[0]   <= w_accept && w_err;
      r_rdata[0] <= w_rd ? r_mem[w_idx] : 32'h0;
      for (int i = 1; i < Latency; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_err[i]   <= r_err[i-1];
        r_rdata[i] <= r_rdata[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst <= '0;
    end else begin
      case ({w_accept, rvalid_o})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

endmodule

// File: tb/tb_vcve2_mem_responder.sv
// Bench for vcve2_mem_responder: directed scenarios plus randomized traffic
// checked against a queue-based transaction model.
module tb_vcve2_mem_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_i, req_i, req1, we_i, gnt_stall_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vcve2_mem_responder #(.Depth(DEPTH), .BaseAddr(BASE), .Latency(LAT), .MaxOutstanding(MAXO)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_stall_i(gnt_stall_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o));

  vcve2_mem_responder #(.Depth(DEPTH), .BaseAddr(BASE), .Latency(LAT), .MaxOutstanding(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req1), .gnt_o(gnt1), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_stall_i(gnt_stall_i),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1));

  // Transaction model of u_dut: pending responses with due cycle, plus a word array.
  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mmem [DEPTH];
  int          cyc = 0;

  function automatic bit m_rv();
    return (q.size() != 0) && (q[0].due == cyc);
  endfunction

  function automatic logic [31:0] m_rd();
    return m_rv() ? q[0].d : 32'h0;
  endfunction

  function automatic bit m_err();
    return m_rv() ? q[0].e : 1'b0;
  endfunction

  function automatic bit m_gnt();
    return !rst_i && !gnt_stall_i && ((q.size() < MAXO) || m_rv());
  endfunction

  bit     mdl_rv, mdl_acc;
  resp_t  mdl_r;
  longint mdl_la;
  int     mdl_idx;

  initial begin
    forever begin
      @(posedge clk);
      mdl_rv  = m_rv();
      mdl_acc = req_i && m_gnt();
      if (mdl_acc) begin
        mdl_la    = longint'(addr_i);
        mdl_r.due = cyc + LAT;
        mdl_r.d   = 32'h0;
        mdl_r.e   = (addr_i % 4 != 0) || (mdl_la < longint'(BASE)) ||
                    (mdl_la >= longint'(BASE) + longint'(DEPTH) * 4);
        if (!mdl_r.e) begin
          mdl_idx = int'((mdl_la - longint'(BASE)) / 4);
          if (we_i) begin
            for (int b = 0; b < 4; b++)
              if (be_i[b]) mmem[mdl_idx][8*b +: 8] = wdata_i[8*b +: 8];
          end else begin
            mdl_r.d = mmem[mdl_idx];
          end
        end
        q.push_back(mdl_r);
      end
      if (mdl_rv) void'(q.pop_front());
      if (rst_i) q.delete();
      cyc++;
    end
  end

  task automatic drive(input logic r, input logic r1, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req_i = r; req1 = r1; we_i = w; be_i = b; addr_i = a; wdata_i = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
      rst_i = 1'b0; gnt_stall_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
      rst_i = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt_o !== 1'b0 || gnt1 !== 1'b0) begin
        errors++; $display("FAIL reset_gnt got %b/%b want 0/0", gnt_o, gnt1);
      end
      checks++;
      if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
        errors++; $display("FAIL reset_outputs got rv=%b rd=%h err=%b want 0/0/0", rvalid_o, rdata_o, err_o);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1) begin
      errors++; $display("FAIL post_reset_gnt got %b want 1", gnt_o);
    end
  endtask

  task automatic test_write_read();
    idle(3);
    drive(1'b1, 1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b want 1", gnt_o); end
    drive(1'b1, 1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
      errors++; $display("FAIL rd_accept got gnt=%b rv=%b want 1/0", gnt_o, rvalid_o);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
      errors++; $display("FAIL wr_resp got rv=%b rd=%h err=%b want 1/00000000/0", rvalid_o, rdata_o, err_o);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
      errors++; $display("FAIL rd_resp got rv=%b rd=%h err=%b want 1/deadbeef/0", rvalid_o, rdata_o, err_o);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rv_pulse got %b want 0", rvalid_o); end
  endtask

  task automatic test_byte_enable();
    idle(3);
    drive(1'b1, 1'b0, 1'b1, 4'b0101, BASE + 32'h10, 32'h1122_3344);
    drive(1'b1, 1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hDE22_BE44) begin
      errors++; $display("FAIL byte_enable got rv=%b rd=%h want 1/de22be44", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5] = '{32'h1000_1000, 32'h1000_0012, 32'h1000_0010, 32'h0FFF_FFFC, 32'hFFFF_FFFC};
    logic        wes   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        exp_e [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_d [5] = '{32'h0, 32'h0, 32'hDE22_BE44, 32'h0, 32'h0};
    idle(3);
    for (int c = 0; c < 7; c++) begin
      if (c < 5) drive(1'b1, 1'b0, wes[c], 4'hF, addrs[c], 32'hFFFF_FFFF);
      else       drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
      @(negedge clk);
      if (c < 5) begin
        checks++;
        if (gnt_o !== 1'b1) begin errors++; $display("FAIL err_gnt[%0d] got %b want 1", c, gnt_o); end
      end
      if (c >= 2) begin
        checks++;
        if (rvalid_o !== 1'b1 || err_o !== exp_e[c-2] || rdata_o !== exp_d[c-2]) begin
          errors++;
          $display("FAIL err_resp[%0d] got rv=%b err=%b rd=%h want 1/%b/%h",
                   c - 2, rvalid_o, err_o, rdata_o, exp_e[c-2], exp_d[c-2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL rstmid_gnt0 got %b want 1", gnt_o); end
    drive(1'b1, 1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b0) begin errors++; $display("FAIL rstmid_gnt_rst got %b want 0", gnt_o); end
    drive(1'b1, 1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got gnt=%b rv=%b want 1/0", gnt_o, rvalid_o);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_dropped got %b want 0", rvalid_o); end
    drive(1'b0, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hDE22_BE44) begin
      errors++; $display("FAIL rstmid_mem got rv=%b rd=%h want 1/de22be44", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_stall();
    idle(3);
    for (int c = 0; c < 7; c++) begin
      drive(c < 5, 1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
      gnt_stall_i = (c >= 1 && c <= 3);
      @(negedge clk);
      if (c < 5) begin
        checks++;
        if (gnt_o !== !(c >= 1 && c <= 3)) begin
          errors++; $display("FAIL stall_gnt[%0d] got %b want %b", c, gnt_o, !(c >= 1 && c <= 3));
        end
      end
      checks++;
      if (rvalid_o !== (c == 2 || c == 6) || (c == 2 && rdata_o !== 32'hDE22_BE44)) begin
        errors++; $display("FAIL stall_rv[%0d] got rv=%b rd=%h want %b", c, rvalid_o, rdata_o, (c == 2 || c == 6));
      end
    end
    gnt_stall_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          sel;
    idle(3);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
      @(negedge clk);
      checks++;
      if (gnt_o !== 1'b1) begin errors++; $display("FAIL init_gnt[%0d] got %b want 1", i, gnt_o); end
    end
    for (int c = 0; c < 400; c++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       a = 32'h1000_1000 + 32'(4 * $urandom_range(0, 3));
        1:       a = BASE - 32'd4;
        2:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        3:       a = 32'hFFFF_FFFC;
        default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      drive($urandom_range(0, 9) < 7, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
      rst_i       = ($urandom_range(0, 99) == 0);
      gnt_stall_i = ($urandom_range(0, 9) < 2);
      @(negedge clk);
      checks++;
      if (gnt_o !== m_gnt()) begin
        errors++; $display("FAIL rand_gnt[%0d] got %b want %b", c, gnt_o, m_gnt());
      end
      checks++;
      if (rvalid_o !== m_rv() || rdata_o !== m_rd() || err_o !== m_err()) begin
        errors++;
        $display("FAIL rand_resp[%0d] got rv=%b rd=%h err=%b want %b/%h/%b",
                 c, rvalid_o, rdata_o, err_o, m_rv(), m_rd(), m_err());
      end
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    idle(3);
    for (int c = 0; c < 11; c++) begin
      drive(c < 8, 1'b0, 1'b0, 4'hF, BASE + 32'(4 * $urandom_range(0, 15)), 32'h0);
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got %b want 1", c, gnt_o); end
      end
      checks++;
      if (rvalid_o !== m_rv() || rdata_o !== m_rd() || err_o !== m_err()) begin
        errors++;
        $display("FAIL b2b_resp[%0d] got rv=%b rd=%h err=%b want %b/%h/%b",
                 c, rvalid_o, rdata_o, err_o, m_rv(), m_rd(), m_err());
      end
    end
  endtask

  task automatic test_outstanding();
    logic [31:0] wd [4];
    bit          acc;
    bit          exp_rv;
    int          rd, nacc;
    idle(3);
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom;
      acc   = 1'b0;
      for (int t = 0; t < 6 && !acc; t++) begin
        drive(1'b0, 1'b1, 1'b1, 4'hF, BASE + 32'h40 + 32'(4 * k), wd[k]);
        @(negedge clk);
        if (gnt1) acc = 1'b1;
      end
      checks++;
      if (!acc) begin errors++; $display("FAIL mo1_write_timeout[%0d] got no grant want grant", k); end
    end
    idle(4);
    rd = 0; nacc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, c < 8, 1'b0, 4'hF, BASE + 32'h40 + 32'(4 * rd), 32'h0);
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (gnt1 !== (c % 2 == 0)) begin
          errors++; $display("FAIL mo1_gnt[%0d] got %b want %b", c, gnt1, (c % 2 == 0));
        end
        if (gnt1 === 1'b1 && req1) nacc++;
        if (c % 2 == 0) rd++;
      end
      exp_rv = (c >= 2) && (c <= 8) && (c % 2 == 0);
      checks++;
      if (rvalid1 !== exp_rv || (exp_rv && (rdata1 !== wd[c/2-1] || err1 !== 1'b0))) begin
        errors++;
        $display("FAIL mo1_resp[%0d] got rv=%b rd=%h err=%b want %b/%h/0",
                 c, rvalid1, rdata1, err1, exp_rv, exp_rv ? wd[c/2-1] : 32'h0);
      end
    end
    checks++;
    if (nacc != 4) begin errors++; $display("FAIL mo1_accepts got %0d want 4", nacc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; req1 = 1'b0; we_i = 1'b0; be_i = 4'h0;
    addr_i = BASE; wdata_i = 32'h0; gnt_stall_i = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_reset_mid();
    test_stall();
    test_random();
    test_back_to_back();
    test_outstanding();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcve2_mem_responder.md
# vcve2_mem_responder

Single-port memory responder for the core's instruction/data bus: the subordinate end of the req/gnt/rvalid protocol the core drives on `instr_*` and `data_*`. It accepts one request per cycle and holds a word-addressed memory with byte-enable writes. Each accepted request gets exactly one in-order response after a fixed, parameterised latency. It is the bench and FPGA memory model behind `vcve2_top` and also serves as the reference responder for protocol checks, including grant throttling, outstanding limits and error signalling.

## Interface
- `Depth`, 1024: memory size in 32-bit words; power of two, ≥ 2.
- `BaseAddr`, 32'h0000_0000: byte address of word 0; aligned to `Depth*4`.
- `Latency`, 1: cycles from request acceptance to `rvalid_o`; range 1..8.
- `MaxOutstanding`, 2: maximum accepted-but-unanswered requests; range 1..8.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- `req_i` in 1: request valid.
- `gnt_o` out 1: request accepted this cycle when `req_i && gnt_o`.
- `we_i` in 1: 1 = write, 0 = read.
- `be_i` in 4: byte enables, bit n covers `wdata_i[8n+7:8n]`.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: write data.
- `gnt_stall_i` in 1: forces `gnt_o` low; used for bench throttling.
- `rvalid_o` out 1: response valid; single-cycle pulse.
- `rdata_o` out 32: read data; valid with `rvalid_o`.
- `err_o` out 1: access error; valid with `rvalid_o`.

## Operation
- Grant: `gnt_o = !rst_i && !gnt_stall_i && (outst_q < MaxOutstanding || rvalid_o)`. It is combinational and does not depend on `req_i`.
- Acceptance: `req_i && gnt_o` at a rising edge. Request fields are sampled only on an accepted edge and ignored otherwise.
- Error check at acceptance:
  - `err = (addr_i[1:0] != 0) || addr_i < BaseAddr || addr_i >= BaseAddr + Depth*4`.
  - Comparisons are 33-bit, so there is no wrap at 0xFFFF_FFFC.
- Word index: `(addr_i - BaseAddr) >> 2`, width `$clog2(Depth)`.
- Accepted write, no error:
  - Enabled bytes are written at the acceptance edge; other bytes are unchanged.
  - `be_i == 0` is legal and changes nothing.
  - Response carries `rdata = 0`, `err = 0`.
- Accepted read, no error: the word is captured at the acceptance edge, so a read accepted the cycle after a write returns the written data. Response carries `err = 0`.
- Error request: memory is never modified. Response carries `rdata = 0`, `err = 1`.
- Response pipeline:
  - `Latency` stages, each holding {valid, rdata, err}.
  - Stage 0 loads at acceptance; the last stage drives `rvalid_o`/`rdata_o`/`err_o` directly from flops.
  - Responses come out strictly in acceptance order.
- Outstanding counter `outst_q`, width `$clog2(MaxOutstanding+1)`:
  - +1 on accept, −1 on `rvalid_o`, unchanged when both happen.
  - Never exceeds `MaxOutstanding` and never underflows.
- Outputs when `rvalid_o = 0`: `rdata_o = 0`, `err_o = 0`.
- Reset:
  - Clears all pipeline valids, `outst_q`, `rdata_o` and `err_o`.
  - Memory contents are not reset and are retained across reset.
  - Requests in flight at reset are dropped; no `rvalid_o` is ever produced for them.

## Timing
- Reset values: `gnt_o = 0` while `rst_i = 1`. `rvalid_o = 0`, `rdata_o = 0`, `err_o = 0` from the first edge with `rst_i = 1`.
- Latency: a request accepted at edge E gives `rvalid_o = 1` in the cycle after edge E+Latency−1. With `Latency = 1`, `rvalid_o` is high in the cycle immediately following acceptance.
- Throughput:
  - One accept per cycle when `MaxOutstanding ≥ Latency`.
  - Otherwise `MaxOutstanding` accepts per `Latency` cycles at steady state.
- Simultaneous accept and retire: allowed at full occupancy through the `|| rvalid_o` term, with no bubble.
- `gnt_stall_i` acts in the same cycle. It does not affect responses already in flight.
- Reset asserted mid-stream: `rvalid_o` is low from the next cycle, and `gnt_o` is low in every cycle that `rst_i` is high.

## Test plan
Configuration: `BaseAddr = 32'h1000_0000`, `Depth = 1024`, `Latency = 2`, `MaxOutstanding = 2` unless noted.

- Write/read: write 0xDEADBEEF to 0x1000_0010 with `be = 4'hF`, then read it. Required: `rvalid_o` exactly 2 cycles after each accept; the read returns `rdata_o = 0xDEADBEEF`, `err_o = 0`; the write response returns `rdata_o = 0`.
- Byte enables: over 0xDEADBEEF, write 0x11223344 with `be = 4'b0101`, then read. Required: `rdata_o = 0xDE22BE44`.
- Outstanding limit: set `MaxOutstanding = 1`, hold `req_i` for 8 reads. Required: `gnt_o` pattern 1,0,1,0,…, 4 accepts, `rvalid_o` in every other cycle, data in order. With the default configuration, required: 8 accepts in 8 consecutive cycles.
- Errors:
  - Read 0x1000_1000 (one past end). Required: `err_o = 1`, `rdata_o = 0`.
  - Write 0x1000_0012 (misaligned). Required: `err_o = 1`, and a following read of 0x1000_0010 still returns its prior value.
  - Address 0x0FFF_FFFC (below base). Required: `err_o = 1`.
- Reset mid-flight: accept a read at 0x1000_0010, assert `rst_i` the next cycle for one cycle. Required: no `rvalid_o` afterwards, `gnt_o = 0` during reset, normal accept on the first cycle after reset, memory word unchanged.
- Stall: hold `gnt_stall_i = 1` with `req_i = 1` for 3 cycles while one response is in flight. Required: no accept, the pending `rvalid_o` is still delivered on time, and an accept follows in the first cycle `gnt_stall_i` drops.
